// File: rtl/alu_arbiter_seq.sv
// Round-robin arbiter/sequencer for two requesters sharing one mini_alu.
// Owns the icc register that feeds ADDC/SUBC carry-in.
module alu_arbiter_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req0_op,
  input  logic [3:0]       req1_op,
  input  logic             req0_setcc,
  input  logic             req1_setcc,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_y,
  output logic [3:0]       rsp_flags,
  output logic [3:0]       icc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  output logic [3:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_y,
  input  logic [3:0]       alu_flags
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic             rr_ptr;
  logic [WIDTH-1:0] a_r, b_r;
  logic [3:0]       op_r;
  logic             setcc_r;
  logic             id_r;
  logic             gnt;

  // A lone requester always wins; rr_ptr only breaks ties.
  always_comb begin
    gnt = rr_ptr;
    case (req_valid)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      default: gnt = rr_ptr;
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    if (state == IDLE && req_valid != 2'b00) req_ready[gnt] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      icc       <= 4'h0;
      a_r       <= '0;
      b_r       <= '0;
      op_r      <= 4'h0;
      setcc_r   <= 1'b0;
      id_r      <= 1'b0;
      rsp_y     <= '0;
      rsp_flags <= 4'h0;
    end else begin
      case (state)
        IDLE: if (req_valid != 2'b00) begin
          a_r     <= gnt ? req1_a : req0_a;
          b_r     <= gnt ? req1_b : req0_b;
          op_r    <= gnt ? req1_op : req0_op;
          setcc_r <= gnt ? req1_setcc : req0_setcc;
          id_r    <= gnt;
          state   <= EXEC;
        end
        EXEC: begin
          rsp_y     <= alu_y;
          rsp_flags <= alu_flags;
          // Shifts and pass ops (1010..1111) leave icc alone even with setcc.
          if (setcc_r && op_r <= 4'd9) icc <= alu_flags;
          state <= RESP;
        end
        RESP: if (rsp_ready) begin
          rr_ptr <= ~id_r;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign alu_a      = a_r;
  assign alu_b      = b_r;
  assign alu_opcode = op_r;
  // Gate cin to EXEC so it stays deterministic when icc moves afterwards.
  assign alu_cin    = (state == EXEC) && (op_r == 4'd1 || op_r == 4'd3) && icc[0];
  assign rsp_valid  = (state == RESP);
  assign rsp_id     = id_r;
endmodule

// File: tb/tb_alu_arbiter_seq.sv
// Bench for alu_arbiter_seq: directed plan items plus randomized traffic
// against a transaction-level model of grant order, icc and results.
module tb_alu_arbiter_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        req0_setcc, req1_setcc;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_y, alu_a, alu_b, alu_y;
  logic [3:0]  rsp_flags, icc, alu_opcode, alu_flags;
  logic        alu_cin;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_arbiter_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_setcc(req0_setcc), .req1_setcc(req1_setcc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_y(rsp_y), .rsp_flags(rsp_flags), .icc(icc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_opcode(alu_opcode),
    .alu_y(alu_y), .alu_flags(alu_flags)
  );

  // Stand-in mini_alu; returns {N,Z,V,C, y}.
  function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op, input logic cin);
    logic [32:0] s;
    logic [31:0] y;
    logic        c, v;
    s = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0:  s = {1'b0, a} + {1'b0, b};
      4'd1:  s = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      4'd2:  s = {1'b0, a} + {1'b0, ~b} + 33'd1;
      4'd3:  s = {1'b0, a} + {1'b0, ~b} + {32'd0, cin};
      default: s = '0;
    endcase
    case (op)
      4'd0, 4'd1: begin y = s[31:0]; c = s[32]; v = (a[31] == b[31]) && (y[31] != a[31]); end
      4'd2, 4'd3: begin y = s[31:0]; c = s[32]; v = (a[31] != b[31]) && (y[31] != a[31]); end
      4'd4:  y = a & b;
      4'd5:  y = a | b;
      4'd6:  y = a ^ b;
      4'd7:  y = ~(a & b);
      4'd8:  y = a & ~b;
      4'd9:  y = ~(a | b);
      4'd10: y = a << b[4:0];
      4'd11: y = a >> b[4:0];
      4'd12: y = $unsigned($signed(a) >>> b[4:0]);
      4'd13: y = a;
      4'd14: y = b;
      default: y = ~b;
    endcase
    return {y[31], (y == 32'd0), v, c, y};
  endfunction

  logic [35:0] alu_out;
  assign alu_out   = alu_ref(alu_a, alu_b, alu_opcode, alu_cin);
  assign alu_y     = alu_out[31:0];
  assign alu_flags = alu_out[35:32];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model state: the block's architectural view, not its encoding.
  logic [3:0]  icc_m = 4'h0;
  logic        rr_m  = 1'b0;
  logic [31:0] last_y;
  logic        last_cin, last_id;

  // Called at posedge+1 with the DUT idle. Presents requests, follows one op
  // through EXEC and RESP, holds off rsp_ready for 'hold' cycles.
  task automatic op_cycle(input logic [1:0] vld,
                          input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] op0, input logic sc0,
                          input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] op1, input logic sc1,
                          input int hold);
    logic        g, cin, sc;
    logic [31:0] a, b, y0;
    logic [3:0]  op, f0;
    logic [35:0] res;
    int          n;
    req0_a = a0; req0_b = b0; req0_op = op0; req0_setcc = sc0;
    req1_a = a1; req1_b = b1; req1_op = op1; req1_setcc = sc1;
    req_valid = vld; rsp_ready = 1'b0;
    g   = (vld == 2'b01) ? 1'b0 : (vld == 2'b10) ? 1'b1 : rr_m;
    a   = g ? a1 : a0;   b  = g ? b1 : b0;
    op  = g ? op1 : op0; sc = g ? sc1 : sc0;
    cin = (op == 4'd1 || op == 4'd3) ? icc_m[0] : 1'b0;
    res = alu_ref(a, b, op, cin);
    #1;
    chk("grant", {30'd0, req_ready}, g ? 32'd2 : 32'd1);
    n = 0;
    while (req_ready == 2'b00 && n < 8) begin @(posedge clk); #1; n++; end
    if (n == 8) chk("grant_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid[g] = 1'b0;
    #1;
    chk("exec_ready", {30'd0, req_ready}, 32'd0);
    chk("exec_valid", {31'd0, rsp_valid}, 32'd0);
    chk("alu_a", alu_a, a);
    chk("alu_b", alu_b, b);
    chk("alu_op", {28'd0, alu_opcode}, {28'd0, op});
    chk("alu_cin", {31'd0, alu_cin}, {31'd0, cin});
    chk("icc_exec", {28'd0, icc}, {28'd0, icc_m});
    last_cin = alu_cin;
    if (sc && op <= 4'd9) icc_m = res[35:32];
    @(posedge clk); #1;
    chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rsp_id", {31'd0, rsp_id}, {31'd0, g});
    chk("rsp_y", rsp_y, res[31:0]);
    chk("rsp_flags", {28'd0, rsp_flags}, {28'd0, res[35:32]});
    chk("icc", {28'd0, icc}, {28'd0, icc_m});
    last_y = rsp_y; last_id = rsp_id;
    y0 = rsp_y; f0 = rsp_flags;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_y", rsp_y, y0);
      chk("bp_flags", {28'd0, rsp_flags}, {28'd0, f0});
      chk("bp_ready", {30'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    rr_m = ~g;
    chk("rsp_done", {31'd0, rsp_valid}, 32'd0);
  endtask

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    req0_op = '0; req1_op = '0; req0_setcc = 1'b0; req1_setcc = 1'b0;
    #12;
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_icc", {28'd0, icc}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_rsp_y", rsp_y, 32'd0);
    chk("rst_ready", {30'd0, req_ready}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD 1 + FFFFFFFF with setcc: zero result, Z and C set.
    op_cycle(2'b01, 32'h1, 32'hFFFF_FFFF, 4'd0, 1'b1, '0, '0, 4'd0, 1'b0, 0);
    chk("first_y", last_y, 32'h0);
    chk("first_icc", {28'd0, icc}, 32'h5);
    // Carry chain into ADDC.
    op_cycle(2'b01, 32'hFFFF_FFFF, 32'h1, 4'd0, 1'b1, '0, '0, 4'd0, 1'b0, 0);
    op_cycle(2'b01, 32'h0, 32'h0, 4'd1, 1'b0, '0, '0, 4'd0, 1'b0, 0);
    chk("addc_cin", {31'd0, last_cin}, 32'd1);
    chk("addc_y", last_y, 32'h1);
    // SLL with setcc leaves icc untouched.
    op_cycle(2'b10, '0, '0, 4'd0, 1'b0, 32'h1, 32'h1F, 4'd10, 1'b1, 0);
    chk("sll_y", last_y, 32'h8000_0000);
    chk("sll_icc", {28'd0, icc}, 32'h5);

    // Reset, then contention: grants 0,1,0; back-pressure on the second.
    rst_n = 1'b0; #1; rst_n = 1'b1; icc_m = 4'h0; rr_m = 1'b0;
    @(posedge clk); #1;
    op_cycle(2'b11, 32'h5, 32'h3, 4'd2, 1'b1, 32'h7, 32'h9, 4'd0, 1'b1, 0);
    chk("cont_id0", {31'd0, last_id}, 32'd0);
    op_cycle(2'b11, 32'h5, 32'h3, 4'd2, 1'b1, 32'h7, 32'h9, 4'd0, 1'b1, 5);
    chk("cont_id1", {31'd0, last_id}, 32'd1);
    op_cycle(2'b11, 32'hA, 32'hA, 4'd3, 1'b1, 32'h7, 32'h9, 4'd0, 1'b1, 0);
    chk("cont_id2", {31'd0, last_id}, 32'd0);

    // Reset during EXEC discards the op.
    req_valid = 2'b01; req0_a = 32'h1; req0_b = 32'hFFFF_FFFF; req0_op = 4'd0; req0_setcc = 1'b1;
    @(posedge clk); #1;
    req_valid = 2'b00;
    rst_n = 1'b0; #1;
    chk("mid_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_alu_a", alu_a, 32'd0);
    chk("mid_icc", {28'd0, icc}, 32'd0);
    chk("mid_ready", {30'd0, req_ready}, 32'd0);
    icc_m = 4'h0; rr_m = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("post_rst_valid", {31'd0, rsp_valid}, 32'd0);
    end

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      op_cycle(2'($urandom_range(1, 3)),
               rnd_word(), rnd_word(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               rnd_word(), rnd_word(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
